// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - key event valid/ready handshake between button front-end and calculator core
interface button_event_arbiter_if #(
  parameter int CODE_W = 2
) ();
  logic              o_key_valid;
  logic [CODE_W-1:0] o_key_code;
  logic              i_key_ready;

  modport master (output o_key_valid, output o_key_code, input i_key_ready);
  modport slave  (input o_key_valid, input o_key_code, output i_key_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - button sync/debounce, press-event queueing and round-robin key delivery
module button_event_arbiter #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int CODE_W          = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  input  logic                   i_clear_overrun,
  output logic [NUM_BUTTONS-1:0] o_pressed,
  output logic                   o_overrun,
  button_event_arbiter_if.master key
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t                 r_state;
  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_stable;
  logic [NUM_BUTTONS-1:0] r_stable_d;
  logic [NUM_BUTTONS-1:0] r_pending;
  logic [CNT_W-1:0]       r_cnt [NUM_BUTTONS];
  logic [CODE_W-1:0]      r_last_grant;

  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_gnt_vec;
  logic                   w_gnt_found;
  logic [CODE_W-1:0]      w_gnt_idx;
  logic                   w_grant;
  logic                   w_drop;

  // Index 'off' positions after 'base', wrapping at NUM_BUTTONS (off is 1..NUM_BUTTONS).
  function automatic logic [CODE_W-1:0] rr_idx(input logic [CODE_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_BUTTONS) s -= NUM_BUTTONS;
    return CODE_W'(s);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= i_buttons;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_pressed = r_stable;
  assign w_press   = r_stable & ~r_stable_d;

  // The arbiter only sees registered pending bits, so a fresh press waits one cycle.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      if (!w_gnt_found && r_pending[rr_idx(r_last_grant, k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = rr_idx(r_last_grant, k);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_gnt_found;

  always_comb begin
    w_gnt_vec = '0;
    if (w_grant) w_gnt_vec[w_gnt_idx] = 1'b1;
  end

  assign w_drop = |(w_press & r_pending & ~w_gnt_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_pending       <= '0;
      r_last_grant    <= CODE_W'(NUM_BUTTONS - 1);
      key.o_key_valid <= 1'b0;
      key.o_key_code  <= '0;
      o_overrun       <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_gnt_vec) | w_press;

      if (w_drop) o_overrun <= 1'b1;
      else if (i_clear_overrun) o_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            key.o_key_valid <= 1'b1;
            key.o_key_code  <= w_gnt_idx;
            r_last_grant    <= w_gnt_idx;
            r_state         <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (key.i_key_ready) begin
            key.o_key_valid <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
